// File: rtl/qc_ldpc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : qc_ldpc_pkg
// Shared sizing and sequencer state encoding for the QC-LDPC parity encoder.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package qc_ldpc_pkg;

  localparam int Z           = 16;
  localparam int NUM_MSG_BLK = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_MSG = 3'd1,
    ST_FETCH    = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/qc_parity_sequencer_cyclic_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cyclic_shift_reg
// Z-bit register that loads a circulant row and rotates it left by one.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module cyclic_shift_reg #(
  parameter int Z = qc_ldpc_pkg::Z
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [Z-1:0] din,
  output logic [Z-1:0] dout
);

  logic [Z-1:0] r_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (load) begin
      r_row <= din;
    end else if (shift_en) begin
      r_row <= {r_row[Z-2:0], r_row[Z-1]};
    end
  end

  assign dout = r_row;

endmodule
`default_nettype wire

// File: rtl/qc_parity_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : qc_parity_sequencer
// Accumulates QC-LDPC parity by XORing rotated generator rows per message bit.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module qc_parity_sequencer #(
  parameter int Z           = qc_ldpc_pkg::Z,
  parameter int NUM_MSG_BLK = qc_ldpc_pkg::NUM_MSG_BLK,
  parameter int ADDR_W      = (NUM_MSG_BLK > 1) ? $clog2(NUM_MSG_BLK) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [Z-1:0]      msg_blk,
  input  logic              msg_valid,
  output logic              msg_ready,
  output logic [ADDR_W-1:0] gen_addr,
  input  logic [Z-1:0]      gen_data,
  output logic [Z-1:0]      parity,
  output logic              parity_valid,
  output logic              busy
);

  import qc_ldpc_pkg::state_t;
  import qc_ldpc_pkg::ST_IDLE;
  import qc_ldpc_pkg::ST_WAIT_MSG;
  import qc_ldpc_pkg::ST_FETCH;
  import qc_ldpc_pkg::ST_SHIFT;
  import qc_ldpc_pkg::ST_DONE;

  localparam int CNT_W = (Z > 1) ? $clog2(Z) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [Z-1:0]      r_parity;
  logic [Z-1:0]      r_msg;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_blk;
  logic              r_parity_valid;
  logic [Z-1:0]      w_sr_out;
  logic              w_cnt_last;
  logic              w_blk_last;

  assign w_cnt_last = (r_cnt == CNT_W'(Z - 1));
  assign w_blk_last = (r_blk == ADDR_W'(NUM_MSG_BLK - 1));

  cyclic_shift_reg #(
    .Z (Z)
  ) u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == ST_FETCH),
    .shift_en (r_state == ST_SHIFT),
    .din      (gen_data),
    .dout     (w_sr_out)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_WAIT_MSG;
      ST_WAIT_MSG: if (msg_valid) w_next = ST_FETCH;
      ST_FETCH:    w_next = ST_SHIFT;
      ST_SHIFT:    if (w_cnt_last) w_next = w_blk_last ? ST_DONE : ST_WAIT_MSG;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_parity       <= '0;
      r_msg          <= '0;
      r_cnt          <= '0;
      r_blk          <= '0;
      r_parity_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered pulse: the parity word is already final while in DONE.
      r_parity_valid <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_parity <= '0;
            r_blk    <= '0;
          end
        end
        ST_WAIT_MSG: begin
          if (msg_valid) r_msg <= msg_blk;
        end
        ST_FETCH: begin
          r_cnt <= '0;
        end
        ST_SHIFT: begin
          if (r_msg[r_cnt]) r_parity <= r_parity ^ w_sr_out;
          if (w_cnt_last) begin
            if (!w_blk_last) r_blk <= r_blk + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign msg_ready    = (r_state == ST_WAIT_MSG);
  assign busy         = (r_state != ST_IDLE);
  assign gen_addr     = r_blk;
  assign parity       = r_parity;
  assign parity_valid = r_parity_valid;

endmodule
`default_nettype wire

// File: tb/tb_qc_parity_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_qc_parity_sequencer
// Directed bench: a 4-block and a 1-block sequencer share stimulus.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_qc_parity_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] msg_blk;
  logic        msg_valid;

  logic        msg_ready4, parity_valid4, busy4;
  logic [1:0]  gen_addr4;
  logic [15:0] gen_data4, parity4;
  logic        msg_ready1, parity_valid1, busy1;
  logic [0:0]  gen_addr1;
  logic [15:0] gen_data1, parity1;

  logic [15:0] rom4 [4];
  logic [15:0] rom1 [2];

  int n_tests;
  int n_fail;

  qc_parity_sequencer #(.Z(16), .NUM_MSG_BLK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_blk(msg_blk),
    .msg_valid(msg_valid), .msg_ready(msg_ready4), .gen_addr(gen_addr4),
    .gen_data(gen_data4), .parity(parity4), .parity_valid(parity_valid4),
    .busy(busy4)
  );

  qc_parity_sequencer #(.Z(16), .NUM_MSG_BLK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .msg_blk(msg_blk),
    .msg_valid(msg_valid), .msg_ready(msg_ready1), .gen_addr(gen_addr1),
    .gen_data(gen_data1), .parity(parity1), .parity_valid(parity_valid1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency generator ROMs.
  always @(posedge clk) begin
    gen_data4 <= rom4[gen_addr4];
    gen_data1 <= rom1[gen_addr1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one codeword on both instances; k counts edges after the start edge.
  task automatic run_cw(input logic [15:0] msg, input int stall_blk, input int stall_len,
                        input int mid_start, input bit do_chk,
                        output int lat4, output logic [15:0] par4, output int n4,
                        output int lat1, output logic [15:0] par1, output int n1,
                        output logic [15:0] par4_end);
    int stalled;
    logic [15:0] held;
    lat4 = -1; lat1 = -1; n4 = 0; n1 = 0; par4 = '0; par1 = '0;
    stalled = 0; held = '0;
    @(posedge clk); #1;
    start = 1'b1; msg_blk = msg; msg_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (do_chk) begin
      check("busy_k0", 32'(busy4), 32'd1);
      check("ready_k0", 32'(msg_ready4), 32'd1);
    end
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk); #1;
      if (parity_valid4) begin
        n4++;
        if (lat4 < 0) begin lat4 = k; par4 = parity4; end
      end
      if (parity_valid1) begin
        n1++;
        if (lat1 < 0) begin lat1 = k; par1 = parity1; end
      end
      if (do_chk && k == 1) check("ready_fetch", 32'(msg_ready4), 32'd0);
      if (do_chk && k == 5) check("busy_shift", 32'(busy4), 32'd1);
      if (do_chk && k == 18) check("addr_blk1", 32'(gen_addr4), 32'd1);
      start = (k == mid_start) ? 1'b1 : 1'b0;
      if (msg_ready4 && int'(gen_addr4) == stall_blk && stalled < stall_len) begin
        if (stalled == 0) held = parity4;
        else begin
          check("stall_ready", 32'(msg_ready4), 32'd1);
          check("stall_parity", 32'(parity4), 32'(held));
        end
        stalled++;
        msg_valid = 1'b0;
      end else begin
        msg_valid = 1'b1;
      end
    end
    par4_end = parity4;
  endtask

  int lat4, n4, lat1, n1;
  logic [15:0] par4, par1, par4_end;
  int cnt_pv;

  initial begin
    n_tests = 0; n_fail = 0;
    rom4[0] = 16'h0001; rom4[1] = 16'h0010; rom4[2] = 16'h0100; rom4[3] = 16'h1000;
    rom1[0] = 16'h0001; rom1[1] = 16'h0000;
    rst_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_blk = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_parity", 32'(parity4), 32'h0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_ready", 32'(msg_ready4), 32'd0);
    check("rst_pv", 32'(parity_valid4), 32'd0);
    check("rst_addr", 32'(gen_addr4), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_cw(16'h0001, -1, 0, -1, 1'b1, lat4, par4, n4, lat1, par1, n1, par4_end);
    check("m1_lat4", 32'(lat4), 32'd73);
    check("m1_par4", 32'(par4), 32'h1111);
    check("m1_n4", 32'(n4), 32'd1);
    check("m1_hold4", 32'(par4_end), 32'h1111);
    check("m1_lat1", 32'(lat1), 32'd19);
    check("m1_par1", 32'(par1), 32'h0001);

    run_cw(16'h0003, -1, 0, -1, 1'b0, lat4, par4, n4, lat1, par1, n1, par4_end);
    check("m3_par1", 32'(par1), 32'h0003);
    check("m3_par4", 32'(par4), 32'h3333);

    run_cw(16'hFFFF, -1, 0, -1, 1'b0, lat4, par4, n4, lat1, par1, n1, par4_end);
    check("mF_par1", 32'(par1), 32'hFFFF);
    check("mF_par4", 32'(par4), 32'h0000);
    check("mF_n1", 32'(n1), 32'd1);

    run_cw(16'h0001, 1, 5, -1, 1'b0, lat4, par4, n4, lat1, par1, n1, par4_end);
    check("stall_lat", 32'(lat4), 32'd78);
    check("stall_par", 32'(par4), 32'h1111);

    run_cw(16'h0001, -1, 0, 10, 1'b0, lat4, par4, n4, lat1, par1, n1, par4_end);
    check("mid_n4", 32'(n4), 32'd1);
    check("mid_lat", 32'(lat4), 32'd73);
    check("mid_par", 32'(par4), 32'h1111);

    // Reset during SHIFT with cnt=7 (edge 9 after start).
    @(posedge clk); #1;
    start = 1'b1; msg_blk = 16'hFFFF; msg_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy4), 32'd0);
    check("mrst_parity", 32'(parity4), 32'h0);
    check("mrst_addr", 32'(gen_addr4), 32'd0);
    check("mrst_ready", 32'(msg_ready4), 32'd0);
    check("mrst_pv", 32'(parity_valid4), 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cnt_pv = 0;
    for (int k = 0; k < 90; k++) begin
      @(posedge clk); #1;
      if (parity_valid4) cnt_pv++;
    end
    check("mrst_no_pv", 32'(cnt_pv), 32'd0);
    run_cw(16'h0001, -1, 0, -1, 1'b0, lat4, par4, n4, lat1, par1, n1, par4_end);
    check("post_rst_lat", 32'(lat4), 32'd73);
    check("post_rst_par", 32'(par4), 32'h1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
